// File: rtl/ireorder_ma_dly_pip_if.sv
// Bus bundle for the inverse re-order memory-address delay line.
// master: the producer side. It drives the control, valid and address, and it
//         observes the delayed address, valid and occupancy.
// slave : the delay line itself.
//  en       advance enable (0 = stall)
//  flush    synchronous clear of the pipe
//  rev_en   digit-reverse MA_i on entry
//  valid_i  MA_i is valid
//  MA_i     input memory address
//  IREMA_o  delayed (optionally reversed) address
//  valid_o  IREMA_o valid
//  occ_o    number of valid entries in the pipe
interface ireorder_ma_dly_pip_if #(
  parameter int MA_WIDTH = 11,
  parameter int OCC_W    = 2
);
  logic                en;
  logic                flush;
  logic                rev_en;
  logic                valid_i;
  logic [MA_WIDTH-1:0] MA_i;
  logic [MA_WIDTH-1:0] IREMA_o;
  logic                valid_o;
  logic [OCC_W-1:0]    occ_o;

  modport master (
    output en, flush, rev_en, valid_i, MA_i,
    input  IREMA_o, valid_o, occ_o
  );

  modport slave (
    input  en, flush, rev_en, valid_i, MA_i,
    output IREMA_o, valid_o, occ_o
  );
endinterface

// File: rtl/ireorder_ma_dly_pip.sv
// Memory-address delay line for the inverse re-order stage of the BFFTP data
// path. It delays the re-order memory address by DEPTH enabled cycles so that
// the address lines up with the butterfly data. The address can be
// digit-reversed on entry. Each stage keeps its own valid bit. The line
// supports stall (en=0) and flush, and it keeps an occupancy count.
// With DEPTH=2, rev_en=0 and en=1 it matches the legacy 2-stage MA pipe
// cycle for cycle.
// Ports:
//  clk    clock
//  rst_n  asynchronous active-low reset; clears data, valids and occupancy
//  bus    ireorder_ma_dly_pip_if.slave (en, flush, rev_en, valid_i, MA_i in;
//         IREMA_o, valid_o, occ_o out)
module ireorder_ma_dly_pip #(
  parameter int MA_WIDTH = 11,
  parameter int DEPTH    = 2,
  parameter int DIGIT_W  = 4,
  parameter int NDIG     = 2,
  parameter int OCC_W    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ireorder_ma_dly_pip_if.slave  bus
);

  if (DEPTH < 1) begin : g_bad_depth
    $error("ireorder_ma_dly_pip: DEPTH must be >= 1");
  end
  if (NDIG * DIGIT_W > MA_WIDTH) begin : g_bad_digits
    $error("ireorder_ma_dly_pip: NDIG*DIGIT_W must not exceed MA_WIDTH");
  end

  // Digit d of the low NDIG digits moves to digit position NDIG-1-d.
  // The upper bits pass through unchanged.
  function automatic logic [MA_WIDTH-1:0] digit_rev(input logic [MA_WIDTH-1:0] a);
    logic [MA_WIDTH-1:0] r;
    r = a;
    for (int d = 0; d < NDIG; d++) begin
      r[(NDIG-1-d)*DIGIT_W +: DIGIT_W] = a[d*DIGIT_W +: DIGIT_W];
    end
    return r;
  endfunction

  logic [MA_WIDTH-1:0] ma_ent;
  logic [MA_WIDTH-1:0] data_p [DEPTH];
  logic [DEPTH-1:0]    vld_p;
  logic [OCC_W-1:0]    occ;
  logic [OCC_W-1:0]    occ_next;

  // Entry transform, ahead of stage 0
  always_comb begin
    ma_ent = bus.rev_en ? digit_rev(bus.MA_i) : bus.MA_i;
  end

  // One entry in and one entry out per enabled edge. The bounds on occ
  // make modular arithmetic in OCC_W bits exact.
  always_comb begin
    occ_next = occ + OCC_W'(bus.valid_i) - OCC_W'(vld_p[DEPTH-1]);
  end

  // Stage 0 .. DEPTH-1. Data loads on every enabled edge whatever valid_i is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_p[k] <= '0;
      end
      vld_p <= '0;
      occ   <= '0;
    end else if (bus.flush) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_p[k] <= '0;
      end
      vld_p <= '0;
      occ   <= '0;
    end else if (bus.en) begin
      data_p[0] <= ma_ent;
      vld_p[0]  <= bus.valid_i;
      for (int k = 1; k < DEPTH; k++) begin
        data_p[k] <= data_p[k-1];
        vld_p[k]  <= vld_p[k-1];
      end
      occ <= occ_next;
    end
  end

  // Output stage boundary
  assign bus.IREMA_o = data_p[DEPTH-1];
  assign bus.valid_o = vld_p[DEPTH-1];
  assign bus.occ_o   = occ;

endmodule

// File: tb/tb_ireorder_ma_dly_pip.sv
// Testbench for ireorder_ma_dly_pip. It runs a per-cycle vector table on a
// DEPTH=2 instance (legacy, reversal, stall, flush), a hand-written
// mid-operation reset, and a scoreboard-checked random sweep over DEPTH=1,4,7.
module tb_ireorder_ma_dly_pip;

  logic clk = 1'b0;
  logic rst_n;
  logic rst_sw_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  ireorder_ma_dly_pip_if #(.MA_WIDTH(11), .OCC_W(2)) mif ();

  ireorder_ma_dly_pip #(
    .MA_WIDTH(11), .DEPTH(2), .DIGIT_W(4), .NDIG(2), .OCC_W(2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif.slave)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Independent reference for 11-bit address, two 4-bit digits
  function automatic logic [10:0] ref_rev(input logic [10:0] a, input logic r);
    return r ? {a[10:8], a[3:0], a[7:4]} : a;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- table vectors (DEPTH=2) ----------------
  typedef struct {
    logic [3:0]  ctl;   // {en, flush, rev_en, valid_i}
    logic [10:0] ma;
    logic        ev;
    logic [10:0] ema;
    logic [1:0]  eocc;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] ctl, input logic [10:0] ma,
                              input logic ev, input logic [10:0] ema, input logic [1:0] eocc);
    vec_t v;
    v.ctl = ctl; v.ma = ma; v.ev = ev; v.ema = ema; v.eocc = eocc;
    return v;
  endfunction

  localparam int NV = 22;
  vec_t tbl [NV];

  // ---------------- random sweep (DEPTH=1,4,7) ----------------
  typedef struct {
    logic [10:0] ma;
    int          due;
  } sb_t;

  localparam int SW_D [3] = '{1, 4, 7};
  localparam int SW_CYC = 600;
  bit sw_go = 1'b0;
  bit sw_done [3] = '{1'b0, 1'b0, 1'b0};

  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int D  = SW_D[g];
    localparam int OW = $clog2(D + 1);

    ireorder_ma_dly_pip_if #(.MA_WIDTH(11), .OCC_W(OW)) sif ();

    ireorder_ma_dly_pip #(
      .MA_WIDTH(11), .DEPTH(D), .DIGIT_W(4), .NDIG(2), .OCC_W(OW)
    ) u_sw (
      .clk   (clk),
      .rst_n (rst_sw_n),
      .bus   (sif.slave)
    );

    initial begin
      sb_t         q[$];
      sb_t         e;
      int          ecnt;
      logic        p_en, p_fl, p_rv, p_v;
      logic [10:0] p_ma;
      logic        exp_v;
      ecnt = 0;
      sif.en = 1'b0; sif.flush = 1'b0; sif.rev_en = 1'b0;
      sif.valid_i = 1'b0; sif.MA_i = '0;
      wait (sw_go);
      for (int i = 0; i < SW_CYC; i++) begin
        p_en = ($urandom_range(0, 3) != 0);
        p_fl = ($urandom_range(0, 31) == 0);
        p_rv = 1'($urandom_range(0, 1));
        p_v  = 1'($urandom_range(0, 1));
        p_ma = 11'($urandom);
        sif.en = p_en; sif.flush = p_fl; sif.rev_en = p_rv;
        sif.valid_i = p_v; sif.MA_i = p_ma;
        step();
        if (p_fl) begin
          q.delete();
        end else if (p_en) begin
          ecnt++;
          if (p_v) begin
            e.ma  = ref_rev(p_ma, p_rv);
            e.due = ecnt + D - 1;
            q.push_back(e);
          end
        end
        while (q.size() > 0 && q[0].due < ecnt) void'(q.pop_front());
        exp_v = (q.size() > 0 && q[0].due == ecnt);
        chk($sformatf("sw_d%0d_valid", D), 32'(sif.valid_o), 32'(exp_v));
        if (exp_v) chk($sformatf("sw_d%0d_addr", D), 32'(sif.IREMA_o), 32'(q[0].ma));
        chk($sformatf("sw_d%0d_occ", D), 32'(sif.occ_o), 32'(q.size()));
      end
      sif.en = 1'b0; sif.valid_i = 1'b0;
      sw_done[g] = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit all_done;
    // Rows: inputs before the edge, expected outputs right after it
    tbl[0]  = mk(4'b1001, 11'h123, 1'b0, 11'h000, 2'd1); // legacy
    tbl[1]  = mk(4'b1000, 11'h000, 1'b1, 11'h123, 2'd1);
    tbl[2]  = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[3]  = mk(4'b1011, 11'h5A3, 1'b0, 11'h000, 2'd1); // reversal
    tbl[4]  = mk(4'b1000, 11'h000, 1'b1, 11'h53A, 2'd1);
    tbl[5]  = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[6]  = mk(4'b1001, 11'h001, 1'b0, 11'h000, 2'd1); // stall
    tbl[7]  = mk(4'b1001, 11'h002, 1'b1, 11'h001, 2'd2);
    tbl[8]  = mk(4'b1001, 11'h003, 1'b1, 11'h002, 2'd2);
    tbl[9]  = mk(4'b0001, 11'h7FF, 1'b1, 11'h002, 2'd2);
    tbl[10] = mk(4'b0001, 11'h7FF, 1'b1, 11'h002, 2'd2);
    tbl[11] = mk(4'b0001, 11'h7FF, 1'b1, 11'h002, 2'd2);
    tbl[12] = mk(4'b1000, 11'h000, 1'b1, 11'h003, 2'd1);
    tbl[13] = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[14] = mk(4'b1001, 11'h0AA, 1'b0, 11'h000, 2'd1); // flush
    tbl[15] = mk(4'b1001, 11'h0BB, 1'b1, 11'h0AA, 2'd2);
    tbl[16] = mk(4'b1101, 11'h0CC, 1'b0, 11'h000, 2'd0);
    tbl[17] = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[18] = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[19] = mk(4'b1001, 11'h111, 1'b0, 11'h000, 2'd1); // flush while stalled
    tbl[20] = mk(4'b0100, 11'h000, 1'b0, 11'h000, 2'd0);
    tbl[21] = mk(4'b1000, 11'h000, 1'b0, 11'h000, 2'd0);

    rst_n = 1'b0; rst_sw_n = 1'b0;
    mif.en = 1'b0; mif.flush = 1'b0; mif.rev_en = 1'b0;
    mif.valid_i = 1'b0; mif.MA_i = '0;
    #3;
    chk("rst_addr",  32'(mif.IREMA_o), 32'h0);
    chk("rst_valid", 32'(mif.valid_o), 32'h0);
    chk("rst_occ",   32'(mif.occ_o),   32'h0);
    #9 rst_n = 1'b1;
    mif.en = 1'b1;
    step();
    chk("idle_valid", 32'(mif.valid_o), 32'h0);
    chk("idle_occ",   32'(mif.occ_o),   32'h0);

    for (int i = 0; i < NV; i++) begin
      {mif.en, mif.flush, mif.rev_en, mif.valid_i} = tbl[i].ctl;
      mif.MA_i = tbl[i].ma;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(mif.valid_o), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_addr", i),  32'(mif.IREMA_o), 32'(tbl[i].ema));
      chk($sformatf("vec%0d_occ", i),   32'(mif.occ_o),   32'(tbl[i].eocc));
    end

    // Reset asserted mid-stream clears without a clock edge
    mif.en = 1'b1; mif.flush = 1'b0; mif.rev_en = 1'b0;
    mif.valid_i = 1'b1; mif.MA_i = 11'h2AB;
    step();
    mif.MA_i = 11'h2AC;
    step();
    chk("pre_rst_valid", 32'(mif.valid_o), 32'h1);
    chk("pre_rst_addr",  32'(mif.IREMA_o), 32'h2AB);
    chk("pre_rst_occ",   32'(mif.occ_o),   32'h2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(mif.valid_o), 32'h0);
    chk("async_rst_addr",  32'(mif.IREMA_o), 32'h0);
    chk("async_rst_occ",   32'(mif.occ_o),   32'h0);
    mif.valid_i = 1'b0; mif.MA_i = '0;
    step();
    #2 rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(mif.valid_o), 32'h0);
    chk("post_rst_occ",   32'(mif.occ_o),   32'h0);
    step();
    chk("post_rst_valid2", 32'(mif.valid_o), 32'h0);
    chk("post_rst_addr2",  32'(mif.IREMA_o), 32'h0);

    // Depth sweep
    rst_sw_n = 1'b1;
    sw_go    = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      all_done = sw_done[0] && sw_done[1] && sw_done[2];
      if (all_done) break;
      @(posedge clk);
    end
    chk("sweep_done", 32'(all_done), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
